// File: rtl/prio_enco_scan.sv
// prio_enco_scan: sequential priority encoder, one index per output beat.
// Build option: define PRIO_ENCO_LSB_FIRST_EN for lowest-index-first order.
module prio_enco_scan #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] d_out,
  output logic             out_last,
  output logic             out_zero
);

  if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
    $error("prio_enco_scan: IDX_W must equal clog2(WIDTH)");
  end
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("prio_enco_scan: WIDTH must be in 2..64");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ZERO
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic [WIDTH-1:0] sel_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             single;

  // Selected bit: the last match of the loop wins.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
`ifdef PRIO_ENCO_LSB_FIRST_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx     = IDX_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
`else
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) begin
        sel_idx     = IDX_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
`endif
  end

  assign single =
    ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = d_in;
          state_d   = (d_in != '0) ? SCAN : ZERO;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (single) state_d = IDLE;
        end
      end
      ZERO: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // in_ready is masked by rst so it is low while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q != IDLE);
  assign d_out     = (state_q == SCAN) ? sel_idx : '0;
  assign out_zero  = (state_q == ZERO);
  assign out_last  = (state_q == ZERO) ||
                     ((state_q == SCAN) && single);

endmodule

// File: tb/tb_prio_enco_scan.sv
// tb_prio_enco_scan: directed checks for prio_enco_scan.
// Covers 8-bit and 12-bit instances, backpressure and reset.
module tb_prio_enco_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d_in;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  d_out;
  logic        out_last;
  logic        out_zero;

  logic        in_valid12;
  logic        in_ready12;
  logic [11:0] d_in12;
  logic        out_valid12;
  logic        out_ready12;
  logic [3:0]  d_out12;
  logic        out_last12;
  logic        out_zero12;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  prio_enco_scan #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out(d_out), .out_last(out_last), .out_zero(out_zero)
  );

  prio_enco_scan #(.WIDTH(12), .IDX_W(4)) dut12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid12), .in_ready(in_ready12), .d_in(d_in12),
    .out_valid(out_valid12), .out_ready(out_ready12),
    .d_out(d_out12), .out_last(out_last12), .out_zero(out_zero12)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic beat(input string tag, input int idx,
                      input bit last, input bit zero);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".d_out"}, 64'(d_out), 64'(idx));
    chk({tag, ".last"}, 64'(out_last), 64'(last));
    chk({tag, ".zero"}, 64'(out_zero), 64'(zero));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
  endtask

  // Called at a negedge while idle; returns at the next negedge.
  task automatic accept(input logic [7:0] v);
    in_valid = 1'b1;
    d_in     = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int  exp3 [7] = '{5, 5, 5, 4, 4, 1, 0};
    bit  rdy3 [7] = '{0, 0, 1, 0, 1, 1, 1};
    int  first12;
    int  second12;
    rst = 1'b1;
    in_valid = 1'b0;
    d_in = '0;
    out_ready = 1'b0;
    in_valid12 = 1'b0;
    d_in12 = '0;
    out_ready12 = 1'b0;

    #2;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.d_out", 64'(d_out), 64'd0);
    chk("rst.out_last", 64'(out_last), 64'd0);
    chk("rst.out_zero", 64'(out_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 64'(in_ready), 64'd1);

    // 0xCC: 7,6,3,2
    out_ready = 1'b1;
    accept(8'hCC);
    beat("cc0", 7, 0, 0);
    chk("cc0.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    beat("cc1", 6, 0, 0);
    @(negedge clk);
    beat("cc2", 3, 0, 0);
    @(negedge clk);
    beat("cc3", 2, 1, 0);
    chk("cc3.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    idle_chk("cc_end");

    // zero vector then single low bit
    accept(8'h00);
    beat("z0", 0, 1, 1);
    @(negedge clk);
    idle_chk("z_end");
    accept(8'h01);
    beat("one", 0, 1, 0);
    @(negedge clk);
    idle_chk("one_end");

    // 0x33 with backpressure and ignored in_valid pulses
    accept(8'h33);
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy3[i];
      in_valid  = (i % 2 == 0) && (i < 6);
      d_in      = 8'hFF;
      beat($sformatf("bp%0d", i), exp3[i], i == 6, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle_chk("bp_end");

    // 0xFF: eight back-to-back beats
    accept(8'hFF);
    for (int i = 7; i >= 0; i--) begin
      beat($sformatf("ff%0d", i), i, i == 0, 0);
      @(negedge clk);
    end
    idle_chk("ff_end");

    // reset mid-scan
    accept(8'h66);
    beat("rs0", 6, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs.out_valid", 64'(out_valid), 64'd0);
    chk("rs.in_ready", 64'(in_ready), 64'd0);
    chk("rs.d_out", 64'(d_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    idle_chk("rs_rel");
    accept(8'h04);
    beat("rs_new", 2, 1, 0);
    @(negedge clk);
    idle_chk("rs_end");

    // 12-bit instance, 0x801
`ifdef PRIO_ENCO_LSB_FIRST_EN
    first12 = 0;
    second12 = 11;
`else
    first12 = 11;
    second12 = 0;
`endif
    chk("w12.in_ready", 64'(in_ready12), 64'd1);
    out_ready12 = 1'b1;
    in_valid12 = 1'b1;
    d_in12 = 12'h801;
    @(negedge clk);
    in_valid12 = 1'b0;
    chk("w12a.valid", 64'(out_valid12), 64'd1);
    chk("w12a.d_out", 64'(d_out12), 64'(first12));
    chk("w12a.last", 64'(out_last12), 64'd0);
    @(negedge clk);
    chk("w12b.valid", 64'(out_valid12), 64'd1);
    chk("w12b.d_out", 64'(d_out12), 64'(second12));
    chk("w12b.last", 64'(out_last12), 64'd1);
    chk("w12b.zero", 64'(out_zero12), 64'd0);
    @(negedge clk);
    chk("w12_end.valid", 64'(out_valid12), 64'd0);
    chk("w12_end.in_ready", 64'(in_ready12), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prio_enco_scan.md
Name: prio_enco_scan

Overview:
Parametrised sequential priority encoder, successor to the fixed 8x3 combinational encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per output beat, highest index first. A zero vector produces a single flagged beat.
- Sits between request-collection logic and any consumer that services requests in priority order, such as an interrupt or arbiter front-end.

Parameters:
WIDTH, 8, number of request bits in d_in (legal range 2..64)
IDX_W, 3, width of d_out; must equal clog2(WIDTH); elaboration error otherwise

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  d_in is offered
in_ready  output  1  block can accept a new vector
d_in  input  WIDTH  request vector
out_valid  output  1  d_out/out_last/out_zero are valid
out_ready  input  1  consumer accepts current beat
d_out  output  IDX_W  index of current highest remaining set bit
out_last  output  1  current beat is the final beat for this vector
out_zero  output  1  accepted vector was all zero; d_out=0 on this beat

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- While rst=1: state=IDLE, pending=0, in_ready=0, out_valid=0, d_out=0, out_last=0, out_zero=0. These values take effect immediately, not at the next edge.
- All outputs are decoded from registered state only; there is no combinational path from d_in, in_valid or out_ready to any output.
- FSM states: IDLE, SCAN, ZERO.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge, d_in is latched into pending.
  - Next state is SCAN if d_in!=0, else ZERO.
- SCAN:
  - in_ready=0, out_valid=1.
  - d_out = index of the highest set bit of pending.
  - out_last=1 iff pending has exactly one bit set.
  - On out_valid&&out_ready at an edge, that bit is cleared in pending.
  - If out_last was 1, the FSM returns to IDLE on the same edge.
- ZERO:
  - in_ready=0, out_valid=1, d_out=0, out_zero=1, out_last=1.
  - On handshake, return to IDLE.
- Latency: vector accepted at edge k makes its first beat visible after edge k, i.e. a handshake is possible at edge k+1.
- Throughput: one beat per cycle while out_ready=1. A vector with P set bits occupies P cycles plus one accept cycle; a zero vector occupies two cycles.
- Backpressure: while out_valid=1 and out_ready=0, d_out, out_last, out_zero and pending hold stable.
- in_valid while in_ready=0 is ignored. The source must hold d_in until in_ready; no data is captured outside IDLE.
- d_out is always in range 0..WIDTH-1. Unused upper indices (WIDTH not a power of 2) are never produced.
- Simultaneous events:
  - In the last-beat cycle, in_ready is still 0. A new vector can be accepted only in the following IDLE cycle; no bypass.
- Reset mid-scan:
  - Remaining bits are discarded and out_valid drops immediately.
  - After release, the block is in IDLE with in_ready=1 at the first clock edge.

Optional Feature:
Macro: PRIO_ENCO_LSB_FIRST_EN
- Defined: scan order is reversed. d_out is the index of the lowest set bit of pending, and that bit is cleared on handshake. out_last and zero handling are unchanged.
- Undefined: highest-index-first order as specified above.

Test Plan:
- WIDTH=8, d_in=8'b11001100 accepted, out_ready=1 -> beats d_out=7,6,3,2 on consecutive cycles; out_last=1 only on 2; out_zero=0; in_ready returns 1 after the last handshake.
- d_in=8'b00000000 -> single beat with d_out=0, out_zero=1, out_last=1; next vector 8'b00000001 -> single beat with d_out=0, out_zero=0, out_last=1.
- d_in=8'b00110011, out_ready toggled 0,0,1,0,1,1,1 -> d_out sequence 5,4,1,0, each held stable through low-ready cycles; in_valid pulses during the scan are ignored.
- d_in=8'b11111111 -> 8 beats, d_out=7..0, out_last on 0; no idle gap between beats.
- d_in=8'b01100110, assert rst after the first beat (d_out=6) -> out_valid=0 immediately; after release, in_ready=1 and new vector 8'b00000100 yields single beat d_out=2.
- WIDTH=12, IDX_W=4, d_in=12'h801 -> beats d_out=11,0; with PRIO_ENCO_LSB_FIRST_EN defined -> d_out=0,11, out_last on 11.
